// File: rtl/dice_kernel_launch_ctrl.sv
// ---------------------------------------------------------------------------
// dice_kernel_launch_ctrl
//
// Sequences one kernel launch on the DICE CGRA subsystem. A packed
// configuration image arrives as a stream of 32-bit valid/ready words:
//   word 0            : header, low CGRA_PIPE_SEL_WIDTH bits = compute latency
//   next CGRA_W words : CGRA fabric configuration, LSW first
//   next GPRF_W words : GPRF port configuration, LSW first
//   next PRED_W words : predicate RF port configuration, LSW first
// After loading, the subsystem and dispatcher are held in clear for
// SETTLE_CYCLES cycles. Then they are released, the dispatcher is enabled, and
// the block waits for cgra_done & disp_done before pulsing kernel_done.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start, abort          launch request pulse / abort the current launch
//   busy                  high whenever not idle
//   cfg_valid/ready/data  configuration word stream
//   cgra_cfg, gprf_cfg,
//   predrf_cfg            unpacked configuration registers
//   cgra_compute_latency  compute-latency field from the header word
//   sub_clr, disp_clr     clear to the subsystem and the dispatcher
//   disp_enable           dispatcher enable
//   disp_done, cgra_done  completion inputs
//   kernel_done           one-cycle completion pulse
//   timeout_err           sticky watchdog flag
//
// Optional feature: define DICE_LAUNCH_TIMEOUT_EN to add a RUN-phase watchdog
// with the TIMEOUT_CYCLES parameter. Without it, timeout_err is tied low and
// RUN waits indefinitely.
//
// Every output comes straight from a flop. The control flops are loaded from
// the next-state value, so they always describe the current state.
// ---------------------------------------------------------------------------
module dice_kernel_launch_ctrl #(
    parameter int NUM_CGRA_IO            = 32,
    parameter int CGRA_CFG_WIDTH         = 2496,
    parameter int GPRF_CFG_BITS_PER_PORT = 49,
    parameter int PRED_CFG_BITS_PER_PORT = 8,
    parameter int CGRA_PIPE_SEL_WIDTH    = 7,
    parameter int SETTLE_CYCLES          = 10
`ifdef DICE_LAUNCH_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES       = 65535
`endif
) (
    input  logic                                              clk,
    input  logic                                              rst_n,
    input  logic                                              start,
    input  logic                                              abort,
    output logic                                              busy,
    input  logic                                              cfg_valid,
    output logic                                              cfg_ready,
    input  logic [31:0]                                       cfg_data,
    output logic [CGRA_CFG_WIDTH-1:0]                         cgra_cfg,
    output logic [NUM_CGRA_IO*GPRF_CFG_BITS_PER_PORT-1:0]     gprf_cfg,
    output logic [NUM_CGRA_IO*PRED_CFG_BITS_PER_PORT-1:0]     predrf_cfg,
    output logic [CGRA_PIPE_SEL_WIDTH-1:0]                    cgra_compute_latency,
    output logic                                              sub_clr,
    output logic                                              disp_clr,
    output logic                                              disp_enable,
    input  logic                                              disp_done,
    input  logic                                              cgra_done,
    output logic                                              kernel_done,
    output logic                                              timeout_err
);

    localparam int GPRF_WIDTH = NUM_CGRA_IO * GPRF_CFG_BITS_PER_PORT;
    localparam int PRED_WIDTH = NUM_CGRA_IO * PRED_CFG_BITS_PER_PORT;

    localparam int CGRA_W = (CGRA_CFG_WIDTH + 31) / 32;
    localparam int GPRF_W = (GPRF_WIDTH + 31) / 32;
    localparam int PRED_W = (PRED_WIDTH + 31) / 32;

    // One counter serves the word index in the load states, the clear-hold
    // count in SETTLE, and the first-cycle marker in RUN.
    localparam int MAX_LD  = (CGRA_W > GPRF_W) ? ((CGRA_W > PRED_W) ? CGRA_W : PRED_W)
                                               : ((GPRF_W > PRED_W) ? GPRF_W : PRED_W);
    localparam int CNT_MAX = (MAX_LD > SETTLE_CYCLES) ? MAX_LD : SETTLE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] CGRA_LAST   = CNT_W'(CGRA_W - 1);
    localparam logic [CNT_W-1:0] GPRF_LAST   = CNT_W'(GPRF_W - 1);
    localparam logic [CNT_W-1:0] PRED_LAST   = CNT_W'(PRED_W - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_HDR     = 3'd1;
    localparam logic [2:0] ST_LD_CGRA = 3'd2;
    localparam logic [2:0] ST_LD_GPRF = 3'd3;
    localparam logic [2:0] ST_LD_PRED = 3'd4;
    localparam logic [2:0] ST_SETTLE  = 3'd5;
    localparam logic [2:0] ST_RUN     = 3'd6;
    localparam logic [2:0] ST_DONE    = 3'd7;

    logic [2:0]                     state_q, state_d;
    logic [CNT_W-1:0]               cnt_q, cnt_d;

    // The image registers are padded to whole words. The bits above each
    // segment's width are never brought out, so they are dropped.
    logic [CGRA_W*32-1:0]           cgra_img_q, cgra_img_d;
    logic [GPRF_W*32-1:0]           gprf_img_q, gprf_img_d;
    logic [PRED_W*32-1:0]           pred_img_q, pred_img_d;
    logic [CGRA_PIPE_SEL_WIDTH-1:0] latency_q, latency_d;

    logic busy_q, busy_d;
    logic cfg_ready_q, cfg_ready_d;
    logic clr_q, clr_d;
    logic disp_enable_q, disp_enable_d;
    logic kernel_done_q, kernel_done_d;

`ifdef DICE_LAUNCH_TIMEOUT_EN
    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
    logic [31:0] run_cnt_q, run_cnt_d;
    logic        timeout_err_q, timeout_err_d;
`endif

    // abort takes priority, so a word presented in an abort cycle is refused.
    logic accept;
    assign accept = cfg_valid & cfg_ready_q & ~abort;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cgra_img_d = cgra_img_q;
        gprf_img_d = gprf_img_q;
        pred_img_d = pred_img_q;
        latency_d  = latency_q;
`ifdef DICE_LAUNCH_TIMEOUT_EN
        run_cnt_d     = '0;
        timeout_err_d = timeout_err_q;
`endif

        if (abort && (state_q != ST_IDLE)) begin
            // The partially loaded configuration is kept, so the image
            // registers are not touched here.
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d    = ST_HDR;
                        cnt_d      = '0;
                        cgra_img_d = '0;
                        gprf_img_d = '0;
                        pred_img_d = '0;
                        latency_d  = '0;
`ifdef DICE_LAUNCH_TIMEOUT_EN
                        timeout_err_d = 1'b0;
`endif
                    end
                end
                ST_HDR: begin
                    if (accept) begin
                        latency_d = cfg_data[CGRA_PIPE_SEL_WIDTH-1:0];
                        state_d   = ST_LD_CGRA;
                        cnt_d     = '0;
                    end
                end
                ST_LD_CGRA: begin
                    if (accept) begin
                        for (int w = 0; w < CGRA_W; w++) begin
                            if (cnt_q == CNT_W'(w)) cgra_img_d[w*32 +: 32] = cfg_data;
                        end
                        if (cnt_q == CGRA_LAST) begin
                            state_d = ST_LD_GPRF;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_LD_GPRF: begin
                    if (accept) begin
                        for (int w = 0; w < GPRF_W; w++) begin
                            if (cnt_q == CNT_W'(w)) gprf_img_d[w*32 +: 32] = cfg_data;
                        end
                        if (cnt_q == GPRF_LAST) begin
                            state_d = ST_LD_PRED;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_LD_PRED: begin
                    if (accept) begin
                        for (int w = 0; w < PRED_W; w++) begin
                            if (cnt_q == CNT_W'(w)) pred_img_d[w*32 +: 32] = cfg_data;
                        end
                        if (cnt_q == PRED_LAST) begin
                            state_d = ST_SETTLE;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_SETTLE: begin
                    if (cnt_q == SETTLE_LAST) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    // A zero count marks the first RUN cycle. The done inputs
                    // may still be stale from the previous kernel then, so
                    // they are only honoured from the second cycle on.
                    cnt_d = CNT_W'(1);
`ifdef DICE_LAUNCH_TIMEOUT_EN
                    run_cnt_d = run_cnt_q + 32'd1;
`endif
                    if ((cnt_q != '0) && cgra_done && disp_done) begin
                        state_d = ST_DONE;
                    end
`ifdef DICE_LAUNCH_TIMEOUT_EN
                    else if (run_cnt_q == TIMEOUT_LAST) begin
                        state_d       = ST_DONE;
                        timeout_err_d = 1'b1;
                    end
`endif
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Decode the control outputs from the next state so they are registered
    // and still line up with the state they describe.
    always_comb begin
        busy_d        = (state_d != ST_IDLE);
        cfg_ready_d   = (state_d == ST_HDR)     || (state_d == ST_LD_CGRA) ||
                        (state_d == ST_LD_GPRF) || (state_d == ST_LD_PRED);
        clr_d         = (state_d != ST_RUN);
        disp_enable_d = (state_d == ST_RUN);
        kernel_done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            cgra_img_q    <= '0;
            gprf_img_q    <= '0;
            pred_img_q    <= '0;
            latency_q     <= '0;
            busy_q        <= 1'b0;
            cfg_ready_q   <= 1'b0;
            clr_q         <= 1'b1;
            disp_enable_q <= 1'b0;
            kernel_done_q <= 1'b0;
`ifdef DICE_LAUNCH_TIMEOUT_EN
            run_cnt_q     <= '0;
            timeout_err_q <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            cgra_img_q    <= cgra_img_d;
            gprf_img_q    <= gprf_img_d;
            pred_img_q    <= pred_img_d;
            latency_q     <= latency_d;
            busy_q        <= busy_d;
            cfg_ready_q   <= cfg_ready_d;
            clr_q         <= clr_d;
            disp_enable_q <= disp_enable_d;
            kernel_done_q <= kernel_done_d;
`ifdef DICE_LAUNCH_TIMEOUT_EN
            run_cnt_q     <= run_cnt_d;
            timeout_err_q <= timeout_err_d;
`endif
        end
    end

    assign busy                 = busy_q;
    assign cfg_ready            = cfg_ready_q;
    assign cgra_cfg             = cgra_img_q[CGRA_CFG_WIDTH-1:0];
    assign gprf_cfg             = gprf_img_q[GPRF_WIDTH-1:0];
    assign predrf_cfg           = pred_img_q[PRED_WIDTH-1:0];
    assign cgra_compute_latency = latency_q;
    assign sub_clr              = clr_q;
    assign disp_clr             = clr_q;
    assign disp_enable          = disp_enable_q;
    assign kernel_done          = kernel_done_q;
`ifdef DICE_LAUNCH_TIMEOUT_EN
    assign timeout_err          = timeout_err_q;
`else
    assign timeout_err          = 1'b0;
`endif

endmodule

// File: tb/tb_dice_kernel_launch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dice_kernel_launch_ctrl
//
// Self-checking bench for dice_kernel_launch_ctrl. Configuration images and
// valid patterns are randomised. The expected register contents come from
// the image layout: bit b of a segment is bit b%32 of that segment's word
// b/32. Expected timing comes from simple rules:
//   - load length is the number of cycles it takes to hand over all words;
//   - SETTLE lasts SETTLE cycles;
//   - completion happens in RUN cycle max(2, cycle the last done input rose),
//     capped by the watchdog when DICE_LAUNCH_TIMEOUT_EN is defined.
// ---------------------------------------------------------------------------
module tb_dice_kernel_launch_ctrl;

    localparam int CGRA_W = 78;
    localparam int GPRF_W = 49;
    localparam int PRED_W = 8;
    localparam int IMG_W  = 1 + CGRA_W + GPRF_W + PRED_W;
    localparam int SETTLE = 10;
`ifdef DICE_LAUNCH_TIMEOUT_EN
    localparam int TIMEOUT = 100;
`endif

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          abort;
    logic          busy;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [31:0]   cfg_data;
    logic [2495:0] cgra_cfg;
    logic [1567:0] gprf_cfg;
    logic [255:0]  predrf_cfg;
    logic [6:0]    cgra_compute_latency;
    logic          sub_clr;
    logic          disp_clr;
    logic          disp_enable;
    logic          disp_done;
    logic          cgra_done;
    logic          kernel_done;
    logic          timeout_err;

    logic [31:0] img [IMG_W];

    int check_count = 0;
    int fail_count  = 0;

    dice_kernel_launch_ctrl #(
        .SETTLE_CYCLES(SETTLE)
`ifdef DICE_LAUNCH_TIMEOUT_EN
        , .TIMEOUT_CYCLES(TIMEOUT)
`endif
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .start               (start),
        .abort               (abort),
        .busy                (busy),
        .cfg_valid           (cfg_valid),
        .cfg_ready           (cfg_ready),
        .cfg_data            (cfg_data),
        .cgra_cfg            (cgra_cfg),
        .gprf_cfg            (gprf_cfg),
        .predrf_cfg          (predrf_cfg),
        .cgra_compute_latency(cgra_compute_latency),
        .sub_clr             (sub_clr),
        .disp_clr            (disp_clr),
        .disp_enable         (disp_enable),
        .disp_done           (disp_done),
        .cgra_done           (cgra_done),
        .kernel_done         (kernel_done),
        .timeout_err         (timeout_err)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Backstop so the run always ends, even if a task bound is somehow missed.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got running, expected finished");
        $fatal(1, "[TB] watchdog expired");
    end

    // Counts one comparison and reports it if the values differ.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_count++;
        if (got !== exp) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Pulses start for one cycle. Returns at the first negedge in the header state.
    task automatic startLaunch();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Streams the image. mode 0 keeps valid high, mode 1 alternates it
    // starting low, and any other mode randomises it. If abort_after >= 0,
    // abort is raised together with a valid word at that image index.
    task automatic applyStimulus(input int mode, input int abort_after,
                                 output int cycles, output int ready_low, output int accepted);
        int idx = 0;
        bit v;
        bit hs;
        cycles    = 0;
        ready_low = 0;
        accepted  = 0;
        while (idx < IMG_W && cycles < 2000) begin
            if (idx == abort_after) begin
                cfg_valid = 1'b1;
                cfg_data  = img[idx];
                abort     = 1'b1;
                @(negedge clk);
                abort     = 1'b0;
                cfg_valid = 1'b0;
                accepted  = idx;
                return;
            end
            case (mode)
                0:       v = 1'b1;
                1:       v = (cycles % 2 == 1);
                default: v = ($urandom_range(0, 1) == 1);
            endcase
            cfg_valid = v;
            cfg_data  = v ? img[idx] : $urandom;
            if (!cfg_ready) ready_low++;
            hs = v && cfg_ready;
            @(negedge clk);
            cycles++;
            if (hs) idx++;
        end
        cfg_valid = 1'b0;
        accepted  = idx;
        checkOutput("load_words", 32'(idx), 32'(IMG_W));
    endtask

    // Compares every configuration word against the first 'accepted' image words.
    task automatic checkImage(input string tag, input int accepted);
        logic [2495:0] ec;
        logic [1567:0] eg;
        logic [255:0]  ep;
        logic [6:0]    el;
        int wi;
        for (int b = 0; b < 2496; b++) begin
            wi = 1 + b / 32;
            ec[b] = (wi < accepted) ? img[wi][b % 32] : 1'b0;
        end
        for (int b = 0; b < 1568; b++) begin
            wi = 1 + CGRA_W + b / 32;
            eg[b] = (wi < accepted) ? img[wi][b % 32] : 1'b0;
        end
        for (int b = 0; b < 256; b++) begin
            wi = 1 + CGRA_W + GPRF_W + b / 32;
            ep[b] = (wi < accepted) ? img[wi][b % 32] : 1'b0;
        end
        el = (accepted > 0) ? img[0][6:0] : 7'd0;
        checkOutput({tag, "_lat"}, 32'(cgra_compute_latency), 32'(el));
        for (int w = 0; w < CGRA_W; w++)
            checkOutput($sformatf("%s_cgra[%0d]", tag, w), cgra_cfg[w*32 +: 32], ec[w*32 +: 32]);
        for (int w = 0; w < GPRF_W; w++)
            checkOutput($sformatf("%s_gprf[%0d]", tag, w), gprf_cfg[w*32 +: 32], eg[w*32 +: 32]);
        for (int w = 0; w < PRED_W; w++)
            checkOutput($sformatf("%s_pred[%0d]", tag, w), predrf_cfg[w*32 +: 32], ep[w*32 +: 32]);
    endtask

    // Called at the first SETTLE negedge. Counts clear-hold cycles until the
    // dispatcher is enabled. The done inputs may already be driven high here.
    task automatic settlePhase(input bit hold_cgra, input bit hold_disp, input string tag);
        int cnt = 0;
        int ready_high = 0;
        int clr_low = 0;
        int kd = 0;
        cgra_done = hold_cgra;
        disp_done = hold_disp;
        while (!disp_enable && cnt < 60) begin
            if (cfg_ready) ready_high++;
            if (!sub_clr || !disp_clr) clr_low++;
            if (kernel_done || !busy) kd++;
            cnt++;
            @(negedge clk);
        end
        checkOutput({tag, "_settle_len"}, 32'(cnt), 32'(SETTLE));
        checkOutput({tag, "_settle_ready"}, 32'(ready_high), 32'd0);
        checkOutput({tag, "_settle_clr"}, 32'(clr_low), 32'd0);
        checkOutput({tag, "_settle_kd"}, 32'(kd), 32'd0);
        checkOutput({tag, "_run_clr"}, 32'({sub_clr, disp_clr}), 32'd0);
    endtask

    // Called at the first RUN negedge. cgra_done and disp_done go high in RUN
    // cycles cgra_at and disp_at (1-based; 0 means already high) and stay
    // high. start is pulsed in cycle start_at (0 means never).
    task automatic runPhase(input int cgra_at, input int disp_at, input int start_at, input string tag);
        int  exp_run;
        int  run_cycles = 0;
        int  pulses = 0;
        int  busy_after = 0;
        int  k = 1;
        bit  seen = 1'b0;
        bit  timed_out = 1'b0;
        exp_run = 2;
        if (cgra_at > exp_run) exp_run = cgra_at;
        if (disp_at > exp_run) exp_run = disp_at;
`ifdef DICE_LAUNCH_TIMEOUT_EN
        if (exp_run > TIMEOUT) begin
            exp_run   = TIMEOUT;
            timed_out = 1'b1;
        end
`endif
        while (!seen && k <= 300) begin
            if (kernel_done) begin
                seen = 1'b1;
                pulses++;
                checkOutput({tag, "_kd_enable"}, 32'(disp_enable), 32'd0);
                checkOutput({tag, "_kd_clr"}, 32'({sub_clr, disp_clr}), 32'd3);
                checkOutput({tag, "_kd_tmo"}, 32'(timeout_err), 32'(timed_out));
            end else begin
                if (disp_enable) run_cycles++;
                cgra_done = (k >= cgra_at);
                disp_done = (k >= disp_at);
                start     = (k == start_at);
                @(negedge clk);
                k++;
            end
        end
        cgra_done = 1'b0;
        disp_done = 1'b0;
        start     = 1'b0;
        checkOutput({tag, "_kd_seen"}, 32'(seen), 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (kernel_done) pulses++;
            if (busy) busy_after++;
        end
        checkOutput({tag, "_run_cycles"}, 32'(run_cycles), 32'(exp_run));
        checkOutput({tag, "_kd_pulses"}, 32'(pulses), 32'd1);
        checkOutput({tag, "_busy_after"}, 32'(busy_after), 32'd0);
    endtask

    initial begin
        int cyc;
        int rl;
        int acc;
        int ca;
        int da;
        rst_n     = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        cfg_valid = 1'b0;
        cfg_data  = '0;
        cgra_done = 1'b0;
        disp_done = 1'b0;

        // Reset values.
        repeat (3) @(negedge clk);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_ready", 32'(cfg_ready), 32'd0);
        checkOutput("rst_clr", 32'({sub_clr, disp_clr}), 32'd3);
        checkOutput("rst_enable", 32'(disp_enable), 32'd0);
        checkOutput("rst_kd", 32'(kernel_done), 32'd0);
        checkOutput("rst_tmo", 32'(timeout_err), 32'd0);
        checkOutput("rst_lat", 32'(cgra_compute_latency), 32'd0);
        checkOutput("rst_cgra0", cgra_cfg[31:0], 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("idle_busy", 32'(busy), 32'd0);

        // Full load with word i = i, then the staggered done inputs.
        for (int i = 0; i < IMG_W; i++) img[i] = 32'(i);
        startLaunch();
        checkOutput("hdr_ready", 32'(cfg_ready), 32'd1);
        checkOutput("hdr_busy", 32'(busy), 32'd1);
        applyStimulus(0, -1, cyc, rl, acc);
        checkOutput("full_cycles", 32'(cyc), 32'd136);
        checkOutput("full_ready_low", 32'(rl), 32'd0);
        settlePhase(1'b0, 1'b0, "full");
        checkOutput("full_cgra_lsw", cgra_cfg[31:0], 32'd1);
        checkOutput("full_cgra_msw", cgra_cfg[2495:2464], 32'd78);
        checkOutput("full_gprf_lsw", gprf_cfg[31:0], 32'd79);
        checkOutput("full_pred_msw", predrf_cfg[255:224], 32'd135);
        checkImage("full", IMG_W);
        runPhase(1, 4, 0, "full");

        // Backpressure: same image with alternating valid. The done inputs
        // are already high when RUN is entered, and start is pulsed in RUN.
        startLaunch();
        applyStimulus(1, -1, cyc, rl, acc);
        checkOutput("bp_cycles", 32'(cyc), 32'd272);
        checkOutput("bp_ready_low", 32'(rl), 32'd0);
        checkOutput("bp_ready_drop", 32'(cfg_ready), 32'd0);
        settlePhase(1'b1, 1'b1, "bp");
        checkImage("bp", IMG_W);
        runPhase(0, 0, 1, "bp");

        // Abort while word 50 is offered. The word must not be taken, and no
        // completion may follow.
        for (int i = 0; i < IMG_W; i++) img[i] = $urandom;
        startLaunch();
        applyStimulus(2, 50, cyc, rl, acc);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_ready", 32'(cfg_ready), 32'd0);
        checkOutput("abort_clr", 32'({sub_clr, disp_clr}), 32'd3);
        checkOutput("abort_enable", 32'(disp_enable), 32'd0);
        checkImage("abort", 50);
        rl = 0;
        for (int i = 0; i < 4; i++) begin
            if (kernel_done || busy) rl++;
            @(negedge clk);
        end
        checkOutput("abort_quiet", 32'(rl), 32'd0);

        // A fresh launch clears the registers and reloads cleanly.
        for (int i = 0; i < IMG_W; i++) img[i] = $urandom;
        startLaunch();
        checkImage("restart_clr", 0);
        applyStimulus(2, -1, cyc, rl, acc);
        checkOutput("restart_ready_low", 32'(rl), 32'd0);
        settlePhase(1'b0, 1'b0, "restart");
        checkImage("restart", IMG_W);
        runPhase(2, 3, 0, "restart");

        // Randomised launches.
        for (int n = 0; n < 3; n++) begin
            for (int i = 0; i < IMG_W; i++) img[i] = $urandom;
            ca = $urandom_range(0, 6);
            da = $urandom_range(0, 6);
            startLaunch();
            applyStimulus(2, -1, cyc, rl, acc);
            checkOutput($sformatf("rnd%0d_ready_low", n), 32'(rl), 32'd0);
            settlePhase(ca == 0, da == 0, $sformatf("rnd%0d", n));
            checkImage($sformatf("rnd%0d", n), IMG_W);
            runPhase(ca, da, $urandom_range(0, 2), $sformatf("rnd%0d", n));
        end

`ifdef DICE_LAUNCH_TIMEOUT_EN
        // Watchdog: the done inputs never rise, so the launch ends by timeout.
        for (int i = 0; i < IMG_W; i++) img[i] = $urandom;
        startLaunch();
        applyStimulus(0, -1, cyc, rl, acc);
        settlePhase(1'b0, 1'b0, "tmo");
        runPhase(1000000, 1000000, 0, "tmo");
        checkOutput("tmo_sticky", 32'(timeout_err), 32'd1);
        startLaunch();
        checkOutput("tmo_cleared", 32'(timeout_err), 32'd0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checkOutput("tmo_abort_idle", 32'(busy), 32'd0);
`else
        checkOutput("no_tmo_flag", 32'(timeout_err), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", check_count, fail_count);
        $finish;
    end

endmodule
